// File: rtl/time_setter.sv
// Front-panel time editor: debounced buttons, calendar-aware field stepping, one-cycle load strobe.
// Latency: button edge -> event DB_CYC+2 cycles, outputs 1 cycle later; no backpressure, events act at once.
module time_setter #(
  parameter int CLK_HZ          = 100000000,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int YEAR_MIN        = 2000,
  parameter int YEAR_MAX        = 2099
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        middle,
  input  logic [14:0] cur_year,
  input  logic [3:0]  cur_month,
  input  logic [4:0]  cur_day,
  input  logic [5:0]  cur_hour,
  input  logic [5:0]  cur_min,
  input  logic [5:0]  cur_sec,
  input  logic [3:0]  cur_week,
  output logic [14:0] year_d,
  output logic [3:0]  month_d,
  output logic [4:0]  day_d,
  output logic [5:0]  hour_d,
  output logic [5:0]  min_d,
  output logic [5:0]  sec_d,
  output logic [3:0]  week_s,
  output logic [2:0]  field,
  output logic        editing,
  output logic        load
);

  localparam int DB_CYC   = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int RPT_DLY  = CLK_HZ / 1000 * REPEAT_DELAY_MS;
  localparam int RPT_RATE = CLK_HZ / 1000 * REPEAT_RATE_MS;
  localparam int RMAX     = (RPT_DLY > RPT_RATE) ? RPT_DLY : RPT_RATE;
  localparam int DBW      = $clog2(DB_CYC + 1);
  localparam int RW       = $clog2(RMAX + 1);
  localparam logic [14:0] Y_MIN = 15'(YEAR_MIN);
  localparam logic [14:0] Y_MAX = 15'(YEAR_MAX);

  typedef enum logic [1:0] {IDLE, CAPTURE, EDIT, COMMIT} state_t;

  function automatic logic is_leap(input logic [14:0] y);
    return (y % 15'd4 == 15'd0) && ((y % 15'd100 != 15'd0) || (y % 15'd400 == 15'd0));
  endfunction

  function automatic logic [4:0] dim(input logic [3:0] m, input logic [14:0] y);
    case (m)
      4'd2:                    return is_leap(y) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      default:                 return 5'd31;
    endcase
  endfunction

  // Wrapping +/-1 within lo..hi; anything already outside the range snaps to the wrap target.
  function automatic logic [14:0] step(input logic [14:0] v, input logic [14:0] lo,
                                       input logic [14:0] hi, input logic inc);
    if (inc) return (v >= hi || v < lo) ? lo : v + 15'd1;
    return (v <= lo || v > hi) ? hi : v - 15'd1;
  endfunction

  // Bit order: 0 up, 1 down, 2 left, 3 right, 4 middle.
  logic [4:0]     raw, sync1, sync2, db, db_q, press;
  logic [DBW-1:0] db_cnt [5];
  logic [RW-1:0]  rpt_cnt [2];
  logic [1:0]     rpt_ph, fire;
  logic           ev_up, ev_dn, ev_left, ev_right, ev_mid;

  assign raw   = {middle, right, left, down, up};
  assign press = db & ~db_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      db_q  <= db;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] == DBW'(DB_CYC - 1)) begin
            db[i]     <= ~db[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DBW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Hold counter counts cycles since the press, then since the last repeat.
  always_comb begin
    fire = '0;
    for (int i = 0; i < 2; i++)
      fire[i] = db[i] && (rpt_ph[i] ? (rpt_cnt[i] == RW'(RPT_RATE)) : (rpt_cnt[i] == RW'(RPT_DLY)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_ph <= '0;
      for (int i = 0; i < 2; i++) rpt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!db[i]) begin
          rpt_cnt[i] <= '0;
          rpt_ph[i]  <= 1'b0;
        end else if (press[i]) begin
          rpt_cnt[i] <= RW'(1);
          rpt_ph[i]  <= 1'b0;
        end else if (fire[i]) begin
          rpt_cnt[i] <= RW'(1);
          rpt_ph[i]  <= 1'b1;
        end else begin
          rpt_cnt[i] <= rpt_cnt[i] + RW'(1);
        end
      end
    end
  end

  assign ev_up    = press[0] | fire[0];
  assign ev_dn    = press[1] | fire[1];
  assign ev_left  = press[2];
  assign ev_right = press[3];
  assign ev_mid   = press[4];

  logic [14:0] y_nx, cap_y;
  logic [3:0]  m_nx, w_nx, cap_m, cap_w;
  logic [4:0]  d_nx, dim_cur, dim_y, dim_m, cap_d;
  logic [5:0]  h_nx, mi_nx, s_nx, cap_h, cap_mi, cap_s;

  assign dim_cur = dim(month_d, year_d);
  assign y_nx    = step(year_d, Y_MIN, Y_MAX, ev_up);
  assign m_nx    = 4'(step(15'(month_d), 15'd1, 15'd12, ev_up));
  assign d_nx    = 5'(step(15'(day_d), 15'd1, 15'(dim_cur), ev_up));
  assign h_nx    = 6'(step(15'(hour_d), 15'd0, 15'd23, ev_up));
  assign mi_nx   = 6'(step(15'(min_d), 15'd0, 15'd59, ev_up));
  assign s_nx    = 6'(step(15'(sec_d), 15'd0, 15'd59, ev_up));
  assign w_nx    = 4'(step(15'(week_s), 15'd0, 15'd6, ev_up));
  assign dim_y   = dim(month_d, y_nx);
  assign dim_m   = dim(m_nx, year_d);

  assign cap_y  = (cur_year < Y_MIN || cur_year > Y_MAX) ? Y_MIN : cur_year;
  assign cap_m  = (cur_month == 4'd0 || cur_month > 4'd12) ? 4'd1 : cur_month;
  assign cap_d  = (cur_day == 5'd0 || cur_day > dim(cap_m, cap_y)) ? 5'd1 : cur_day;
  assign cap_h  = (cur_hour > 6'd23) ? 6'd0 : cur_hour;
  assign cap_mi = (cur_min > 6'd59) ? 6'd0 : cur_min;
  assign cap_s  = (cur_sec > 6'd59) ? 6'd0 : cur_sec;
  assign cap_w  = (cur_week > 4'd6) ? 4'd0 : cur_week;

  state_t state;
  logic   enable_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      enable_q <= 1'b0;
      year_d   <= Y_MIN;
      month_d  <= 4'd1;
      day_d    <= 5'd1;
      hour_d   <= '0;
      min_d    <= '0;
      sec_d    <= '0;
      week_s   <= '0;
      field    <= '0;
      editing  <= 1'b0;
      load     <= 1'b0;
    end else begin
      enable_q <= enable;
      load     <= 1'b0;
      case (state)
        IDLE: begin
          editing <= 1'b0;
          if (enable && !enable_q) state <= CAPTURE;
        end
        CAPTURE: begin
          year_d  <= cap_y;
          month_d <= cap_m;
          day_d   <= cap_d;
          hour_d  <= cap_h;
          min_d   <= cap_mi;
          sec_d   <= cap_s;
          week_s  <= cap_w;
          field   <= 3'd0;
          editing <= 1'b1;
          state   <= EDIT;
        end
        EDIT: begin
          if (!enable) begin
            editing <= 1'b0;
            state   <= IDLE;
          end else if (ev_mid) begin
            load  <= 1'b1;
            state <= COMMIT;
          end else if (ev_left) begin
            field <= (field == 3'd0) ? 3'd6 : field - 3'd1;
          end else if (ev_right) begin
            field <= (field >= 3'd6) ? 3'd0 : field + 3'd1;
          end else if (ev_up || ev_dn) begin
            case (field)
              3'd0: begin
                year_d <= y_nx;
                if (day_d > dim_y) day_d <= dim_y;
              end
              3'd1: begin
                month_d <= m_nx;
                if (day_d > dim_m) day_d <= dim_m;
              end
              3'd2:    day_d  <= d_nx;
              3'd3:    hour_d <= h_nx;
              3'd4:    min_d  <= mi_nx;
              3'd5:    sec_d  <= s_nx;
              3'd6:    week_s <= w_nx;
              default: ;
            endcase
          end
        end
        COMMIT: begin
          editing <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_time_setter.sv
// Directed bench for time_setter: expected output snapshots queued with their cycle; a monitor checks every output change.
module tb_time_setter;

  localparam logic [4:0] B_UP = 5'b00001, B_DN = 5'b00010, B_LF = 5'b00100,
                         B_RT = 5'b01000, B_MD = 5'b10000;

  logic        clk, rst, enable;
  logic        up, down, left, right, middle;
  logic [4:0]  btns;
  logic [14:0] cur_year, year_d;
  logic [3:0]  cur_month, cur_week, month_d, week_s;
  logic [4:0]  cur_day, day_d;
  logic [5:0]  cur_hour, cur_min, cur_sec, hour_d, min_d, sec_d;
  logic [2:0]  field;
  logic        editing, load;

  assign {middle, right, left, down, up} = btns;

  time_setter #(
    .CLK_HZ(1000), .DEBOUNCE_MS(4), .REPEAT_DELAY_MS(10), .REPEAT_RATE_MS(3),
    .YEAR_MIN(2000), .YEAR_MAX(2099)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .up(up), .down(down), .left(left), .right(right), .middle(middle),
    .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day), .cur_hour(cur_hour),
    .cur_min(cur_min), .cur_sec(cur_sec), .cur_week(cur_week),
    .year_d(year_d), .month_d(month_d), .day_d(day_d), .hour_d(hour_d),
    .min_d(min_d), .sec_d(sec_d), .week_s(week_s),
    .field(field), .editing(editing), .load(load)
  );

  typedef struct packed {
    logic [14:0] year;
    logic [3:0]  month;
    logic [4:0]  day;
    logic [5:0]  hour;
    logic [5:0]  min;
    logic [5:0]  sec;
    logic [3:0]  week;
    logic [2:0]  field;
    logic        editing;
    logic        load;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t v;
    string name;
  } exp_t;

  exp_t  sb[$];
  exp_t  pend[$];
  snap_t m, live;
  int    cyc = 0;
  int    vec = 0;
  int    err = 0;
  logic  mon_en = 1'b0;

  assign live = '{year_d, month_d, day_d, hour_d, min_d, sec_d, week_s, field, editing, load};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string fmt(input snap_t s);
    return $sformatf("%0d-%0d-%0d %0d:%0d:%0d wk%0d field%0d editing%0b load%0b",
                     s.year, s.month, s.day, s.hour, s.min, s.sec, s.week, s.field, s.editing, s.load);
  endfunction

  // Expectations are staged with a cycle offset relative to the next stimulus action.
  task automatic stage(input int off, input string nm);
    exp_t e;
    e.cyc  = off;
    e.v    = m;
    e.name = nm;
    pend.push_back(e);
  endtask

  task automatic flush();
    foreach (pend[i]) begin
      exp_t e;
      e     = pend[i];
      e.cyc = e.cyc + cyc;
      sb.push_back(e);
    end
    pend.delete();
  endtask

  task automatic press(input logic [4:0] mask, input int hold);
    @(posedge clk); #1;
    flush();
    btns = mask;
    repeat (hold) @(posedge clk);
    #1 btns = '0;
    repeat (10) @(posedge clk);
  endtask

  task automatic set_enable(input logic v);
    @(posedge clk); #1;
    flush();
    enable = v;
    repeat (4) @(posedge clk);
  endtask

  task automatic set_cur(input int y, input int mo, input int d, input int h,
                         input int mi, input int s, input int w);
    cur_year = 15'(y); cur_month = 4'(mo); cur_day = 5'(d); cur_hour = 6'(h);
    cur_min = 6'(mi); cur_sec = 6'(s); cur_week = 4'(w);
  endtask

  task automatic set_model(input int y, input int mo, input int d, input int h,
                           input int mi, input int s, input int w);
    m = '{15'(y), 4'(mo), 5'(d), 6'(h), 6'(mi), 6'(s), 4'(w), 3'd0, 1'b1, 1'b0};
  endtask

  // Monitor: every visible change of the output bus consumes one expectation.
  initial begin : monitor
    snap_t prev;
    logic  started;
    exp_t  e;
    started = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && (!started || live !== prev)) begin
        vec++;
        if (sb.size() == 0) begin
          err++;
          $display("FAIL unexpected_change cyc %0d: got %s, required no change from %s", cyc, fmt(live), fmt(prev));
        end else begin
          e = sb.pop_front();
          if (live !== e.v || (e.cyc >= 0 && cyc != e.cyc)) begin
            err++;
            $display("FAIL %s: got %s at cyc %0d, required %s at cyc %0d",
                     e.name, fmt(live), cyc, fmt(e.v), e.cyc);
          end
        end
        prev    = live;
        started = 1'b1;
      end
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; btns = '0;
    set_cur(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    m = '{15'd2000, 4'd1, 5'd1, 6'd0, 6'd0, 6'd0, 4'd0, 3'd0, 1'b0, 1'b0};
    stage(-1000000, "reset");
    flush();
    sb[0].cyc = -1;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);

    // Capture, glitch rejection, debounce latency, field wrap, commit.
    set_cur(2023, 5, 17, 13, 45, 30, 3);
    set_model(2023, 5, 17, 13, 45, 30, 3); stage(2, "capture1");
    set_enable(1'b1);
    @(posedge clk); #1 btns = B_UP;
    repeat (2) @(posedge clk);
    #1 btns = '0;
    repeat (12) @(posedge clk);
    m.year = 15'd2024; stage(7, "up_year_latency"); press(B_UP, 8);
    m.field = 3'd6;    stage(7, "left_wrap");       press(B_LF, 8);
    m.field = 3'd0;    stage(7, "right_wrap");      press(B_RT, 8);
    m.field = 3'd1;    stage(7, "right_to_month");  press(B_RT, 8);
    m.load = 1'b1; stage(7, "commit_load");
    m.load = 1'b0; m.editing = 1'b0; stage(8, "commit_end");
    press(B_MD, 8);
    repeat (5) @(posedge clk);
    set_enable(1'b0);

    // Month/year changes clamp the day; abort keeps edits without load.
    set_cur(2024, 1, 31, 10, 20, 30, 1);
    set_model(2024, 1, 31, 10, 20, 30, 1); stage(2, "capture2");
    set_enable(1'b1);
    m.field = 3'd1; stage(7, "sel_month"); press(B_RT, 8);
    m.month = 4'd2; m.day = 5'd29; stage(7, "month_up_clamp29"); press(B_UP, 8);
    m.field = 3'd0; stage(7, "sel_year"); press(B_LF, 8);
    m.year = 15'd2023; m.day = 5'd28; stage(7, "year_down_clamp28"); press(B_DN, 8);
    m.editing = 1'b0; stage(1, "abort2");
    set_enable(1'b0);

    // Out-of-range snapshot is sanitised to range minimums.
    set_cur(2100, 13, 0, 24, 60, 61, 7);
    set_model(2000, 1, 1, 0, 0, 0, 0); stage(2, "capture_out_of_range");
    set_enable(1'b1);
    m.editing = 1'b0; stage(1, "abort3");
    set_enable(1'b0);

    // Boundary wraps, auto-repeat, simultaneous middle+up.
    set_cur(2023, 1, 31, 23, 58, 0, 6);
    set_model(2023, 1, 31, 23, 58, 0, 6); stage(2, "capture4");
    set_enable(1'b1);
    m.field = 3'd1; stage(7, "sel_month4"); press(B_RT, 8);
    m.month = 4'd12; stage(7, "month_wrap_down"); press(B_DN, 8);
    m.field = 3'd2; stage(7, "sel_day4"); press(B_RT, 8);
    m.field = 3'd3; stage(7, "sel_hour4"); press(B_RT, 8);
    m.hour = 6'd0; stage(7, "hour_wrap_up"); press(B_UP, 8);
    m.field = 3'd4; stage(7, "sel_min4"); press(B_RT, 8);
    m.min = 6'd59; stage(7, "repeat_press");
    m.min = 6'd0;  stage(17, "repeat_first");
    m.min = 6'd1;  stage(20, "repeat_second");
    m.min = 6'd2;  stage(23, "repeat_third");
    m.min = 6'd3;  stage(26, "repeat_fourth");
    press(B_UP, 20);
    m.field = 3'd5; stage(7, "sel_sec4"); press(B_RT, 8);
    m.sec = 6'd59; stage(7, "sec_wrap_down"); press(B_DN, 8);
    m.field = 3'd6; stage(7, "sel_week4"); press(B_RT, 8);
    m.week = 4'd0; stage(7, "week_wrap_up"); press(B_UP, 8);
    m.load = 1'b1; stage(7, "mid_up_commit_load");
    m.load = 1'b0; m.editing = 1'b0; stage(8, "mid_up_commit_end");
    press(B_MD | B_UP, 8);
    set_enable(1'b0);

    // Year wrap at YEAR_MAX and leap-year day range of Feb 2000.
    set_cur(2099, 2, 28, 12, 0, 0, 2);
    set_model(2099, 2, 28, 12, 0, 0, 2); stage(2, "capture5");
    set_enable(1'b1);
    m.year = 15'd2000; stage(7, "year_wrap_max"); press(B_UP, 8);
    m.field = 3'd1; stage(7, "sel_month5"); press(B_RT, 8);
    m.field = 3'd2; stage(7, "sel_day5"); press(B_RT, 8);
    m.day = 5'd29; stage(7, "day_up_leap29"); press(B_UP, 8);
    m.day = 5'd1;  stage(7, "day_wrap_dim29"); press(B_UP, 8);
    m.editing = 1'b0; stage(1, "abort5");
    set_enable(1'b0);

    repeat (20) @(posedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vec++;
      err++;
      $display("FAIL %s: got no output change, required %s at cyc %0d", e.name, fmt(e.v), e.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
